// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit front end: handoff FSM states and default sizes.
package uart_tx_feeder_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned BIT_RESOLUTION = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_START = 3'b010,
    ST_WAIT  = 3'b100
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a one-cycle overflow pulse.
// The head word is presented combinationally on o_rd_data; shared with the RX path.
module uart_sync_fifo #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [WORD_WIDTH-1:0]         i_wr_data,
  input  logic                          i_pop,
  output logic [WORD_WIDTH-1:0]         o_rd_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic [AW:0]           w_count_nxt;

  // Fullness is judged on the registered flag only; a same-cycle pop does not admit a write.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == FULL_CNT);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= i_push & r_full;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered UART transmit front end: host writes go into a FIFO, and a handoff FSM feeds one
// word at a time to the transmitter over tx_start/tx_data/tx_done.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [WORD_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_start,
  output logic [WORD_WIDTH-1:0]         tx_data,
  input  logic                          tx_done
);

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic                  r_busy;
  logic                  r_tx_start;
  logic [WORD_WIDTH-1:0] r_tx_data;

  logic                  w_pop;
  logic                  w_empty;
  logic [WORD_WIDTH-1:0] w_head;

  uart_sync_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (wr_en),
    .i_wr_data  (wr_data),
    .i_pop      (w_pop),
    .o_rd_data  (w_head),
    .o_full     (full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // tx_start and busy are registered from the next state so they align with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_tx_start <= (w_state_nxt == ST_START);
      if (w_pop) r_tx_data <= w_head;
    end
  end

  assign empty    = w_empty;
  assign busy     = r_busy;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule
